fpadd_issue_ctrl: RTL and testbench

Issue controller and scheduler for the floating-point add pipeline built around the significand adder.
- Arbitrates round-robin between two requesters sharing one adder pipeline.
- Computes the effective-subtraction control sx for each operation and delivers it to the significand-add stage.
- Sequences operations through a STAGES-deep pipeline with valid/ready backpressure.
- Returns each result with its requester ID and tag.

---
 rtl/fpadd_issue_ctrl_if.sv | 42 ++++
 rtl/fpadd_issue_ctrl.sv | 110 +++++++++++
 tb/tb_fpadd_issue_ctrl.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpadd_issue_ctrl_if.sv
// Handshake bundle for the FP-add issue controller:
// two requester ports plus the result port.
interface fpadd_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in0_valid;
  logic             in0_ready;
  logic             in0_sub;
  logic             in0_sa;
  logic             in0_sb;
  logic [TAG_W-1:0] in0_tag;

  logic             in1_valid;
  logic             in1_ready;
  logic             in1_sub;
  logic             in1_sa;
  logic             in1_sb;
  logic [TAG_W-1:0] in1_tag;

  logic             out_valid;
  logic             out_ready;
  logic             out_id;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in0_valid, in0_sub, in0_sa, in0_sb, in0_tag,
    output in0_ready,
    input  in1_valid, in1_sub, in1_sa, in1_sb, in1_tag,
    output in1_ready,
    output out_valid, out_id, out_tag,
    input  out_ready
  );

  modport master (
    output in0_valid, in0_sub, in0_sa, in0_sb, in0_tag,
    input  in0_ready,
    output in1_valid, in1_sub, in1_sa, in1_sb, in1_tag,
    input  in1_ready,
    input  out_valid, out_id, out_tag,
    output out_ready
  );
endinterface

// File: rtl/fpadd_issue_ctrl.sv
// Issue/scheduling control for the FP-add pipeline:
// round-robin arbitration, sx tracking, stage valids.
module fpadd_issue_ctrl #(
  parameter int STAGES       = 4,
  parameter int SIGADD_STAGE = 2,
  parameter int TAG_W        = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  fpadd_issue_ctrl_if.slave               bus,
  output logic                            op_sel,
  output logic [STAGES-1:0]               st_en,
  output logic                            sx_sig,
  output logic [$clog2(STAGES+1)-1:0]     inflight
);

  localparam int SG = SIGADD_STAGE - 1;
  localparam int CW = $clog2(STAGES + 1);

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_id;
  logic [STAGES-1:0] r_sx;
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic              r_ptr;

  logic              w_adv;
  logic              w_ok;
  logic              w_both;
  logic              w_g0;
  logic              w_g1;
  logic              w_any;
  logic              w_sx_in;
  logic [TAG_W-1:0]  w_tag_in;
  logic [CW-1:0]     w_cnt;

  // The pipe only moves when the last stage is empty or draining.
  assign w_adv  = ~(r_v[STAGES-1] & ~bus.out_ready);
  assign w_ok   = w_adv & ~flush;
  assign w_both = bus.in0_valid & bus.in1_valid;

  assign w_g0 = w_ok & bus.in0_valid
              & (~bus.in1_valid | ~r_ptr);
  assign w_g1 = w_ok & bus.in1_valid
              & (~bus.in0_valid | r_ptr);
  assign w_any = w_g0 | w_g1;

  assign bus.in0_ready = w_g0;
  assign bus.in1_ready = w_g1;
  assign op_sel        = w_g1;
  assign st_en         = {STAGES{w_adv}};

  // Operand-side mux for the op entering stage 1.
  always_comb begin
    w_sx_in  = 1'b0;
    w_tag_in = '0;
    unique case (1'b1)
      w_g1: begin
        w_sx_in  = bus.in1_sa ^ bus.in1_sb ^ bus.in1_sub;
        w_tag_in = bus.in1_tag;
      end
      default: begin
        w_sx_in  = bus.in0_sa ^ bus.in0_sb ^ bus.in0_sub;
        w_tag_in = bus.in0_tag;
      end
    endcase
  end

  // Stage valid/id/sx/tag shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v  <= '0;
      r_id <= '0;
      r_sx <= '0;
      for (int i = 0; i < STAGES; i++)
        r_tag[i] <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else if (w_adv) begin
      r_v      <= {r_v[STAGES-2:0], w_any};
      r_id     <= {r_id[STAGES-2:0], w_g1};
      r_sx     <= {r_sx[STAGES-2:0], w_sx_in};
      r_tag[0] <= w_tag_in;
      for (int i = 1; i < STAGES; i++)
        r_tag[i] <= r_tag[i-1];
    end
  end

  // Round-robin pointer flips only on contended grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ptr <= 1'b0;
    else if (w_ok & w_both)
      r_ptr <= ~r_ptr;
  end

  // Occupancy count of the stage valid bits.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < STAGES; i++)
      w_cnt = w_cnt + CW'(r_v[i]);
  end

  assign inflight      = w_cnt;
  assign sx_sig        = r_v[SG] & r_sx[SG];
  assign bus.out_valid = r_v[STAGES-1];
  assign bus.out_id    = r_id[STAGES-1];
  assign bus.out_tag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Self-checking bench for fpadd_issue_ctrl:
// directed scenarios plus randomized run vs a queue model.
module tb_fpadd_issue_ctrl;
  localparam int S  = 4;
  localparam int SG = 2;
  localparam int TW = 4;
  localparam int CW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          op_sel;
  logic          sx_sig;
  logic [S-1:0]  st_en;
  logic [CW-1:0] inflight;

  fpadd_issue_ctrl_if #(.TAG_W(TW)) bus();

  fpadd_issue_ctrl #(
    .STAGES(S), .SIGADD_STAGE(SG), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .bus(bus.slave), .op_sel(op_sel), .st_en(st_en),
    .sx_sig(sx_sig), .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic          id;
    logic [TW-1:0] tag;
    logic          sx;
  } slot_t;

  slot_t pipe[$];
  logic  mptr;
  int    vec = 0;
  int    errs = 0;
  int    cyc = 0;
  logic  e_r0, e_r1, e_sel, e_any, e_adv;

  task automatic m_reset();
    pipe.delete();
    for (int i = 0; i < S; i++) pipe.push_back('0);
    mptr = 1'b0;
  endtask

  task automatic m_expect();
    e_adv = !(pipe[S-1].v && !bus.out_ready);
    e_sel = 1'b0;
    e_r0  = 1'b0;
    e_r1  = 1'b0;
    if (e_adv && !flush) begin
      if (bus.in0_valid && bus.in1_valid) e_sel = mptr;
      else e_sel = bus.in1_valid;
      e_r0 = bus.in0_valid && !e_sel;
      e_r1 = bus.in1_valid && e_sel;
    end
    e_any = e_r0 | e_r1;
  endtask

  task automatic m_commit();
    slot_t n;
    m_expect();
    if (flush) begin
      for (int i = 0; i < S; i++) pipe[i].v = 1'b0;
    end else if (e_adv) begin
      n.v   = e_any;
      n.id  = e_sel;
      n.tag = e_sel ? bus.in1_tag : bus.in0_tag;
      n.sx  = e_sel ? (bus.in1_sa ^ bus.in1_sb ^ bus.in1_sub)
                    : (bus.in0_sa ^ bus.in0_sb ^ bus.in0_sub);
      void'(pipe.pop_back());
      pipe.push_front(n);
      if (e_any && bus.in0_valid && bus.in1_valid) mptr = ~mptr;
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < S; i++) c += int'(pipe[i].v);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_commit();
    else m_reset();
    cyc++;
    @(negedge clk);
  endtask

  task automatic set0(logic v, logic sub, logic sa, logic sb,
                      logic [TW-1:0] tag);
    bus.in0_valid = v; bus.in0_sub = sub;
    bus.in0_sa = sa; bus.in0_sb = sb; bus.in0_tag = tag;
  endtask

  task automatic set1(logic v, logic sub, logic sa, logic sb,
                      logic [TW-1:0] tag);
    bus.in1_valid = v; bus.in1_sub = sub;
    bus.in1_sa = sa; bus.in1_sb = sb; bus.in1_tag = tag;
  endtask

  task automatic drain();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    flush = 1'b0;
    repeat (S + 1) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set0(1, 1, 0, 0, 4'h5);
    set1(1, 0, 1, 0, 4'h6);
    bus.out_ready = 1'b0;
    m_reset();
    repeat (3) tick();
    vec++;
    if (bus.out_valid !== 1'b0 || inflight !== '0) begin
      errs++;
      $display("FAIL reset_valid: out_valid=%b inflight=%0d req 0/0",
               bus.out_valid, inflight);
    end
    vec++;
    if (sx_sig !== 1'b0 || bus.out_id !== 1'b0 ||
        bus.out_tag !== '0) begin
      errs++;
      $display("FAIL reset_out: sx=%b id=%b tag=%h req 0/0/0",
               sx_sig, bus.out_id, bus.out_tag);
    end
    rst_n = 1'b1;
    drain();
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    set0(1, 1, 0, 0, 4'd3);
    #1;
    vec++;
    if (bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0 ||
        op_sel !== 1'b0) begin
      errs++;
      $display("FAIL single_issue: r0=%b r1=%b sel=%b req 1/0/0",
               bus.in0_ready, bus.in1_ready, op_sel);
    end
    tick();
    set0(0, 0, 0, 0, 0);
    for (int c = 1; c <= S + 1; c++) begin
      vec++;
      if (sx_sig !== (c == SG) || bus.out_valid !== (c == S) ||
          inflight !== CW'(c <= S)) begin
        errs++;
        $display("FAIL single_c%0d: sx=%b ov=%b inf=%0d req %b/%b/%0d",
                 c, sx_sig, bus.out_valid, inflight,
                 c == SG, c == S, c <= S);
      end
      if (c == S) begin
        vec++;
        if (bus.out_id !== 1'b0 || bus.out_tag !== 4'd3) begin
          errs++;
          $display("FAIL single_out: id=%b tag=%0d req 0/3",
                   bus.out_id, bus.out_tag);
        end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    slot_t q[$];
    int    iss[$];
    int    c0 = 0;
    int    c1 = 0;
    slot_t e;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set0(1, 0, 0, 0, TW'(c0));
      set1(1, 0, 0, 0, TW'(c1));
      #1;
      vec++;
      if (bus.in0_ready !== (k % 2 == 0) ||
          bus.in1_ready !== (k % 2 == 1)) begin
        errs++;
        $display("FAIL contend_g%0d: r0=%b r1=%b req %b/%b", k,
                 bus.in0_ready, bus.in1_ready, k % 2 == 0, k % 2 == 1);
      end
      e = '0;
      e.id = (k % 2 == 1);
      e.tag = e.id ? TW'(c1) : TW'(c0);
      q.push_back(e);
      iss.push_back(cyc);
      if (e.id) c1++;
      else c0++;
      tick();
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    for (int t = 0; t < 12 && q.size() > 0; t++) begin
      if (bus.out_valid) begin
        e = q.pop_front();
        vec++;
        if (bus.out_id !== e.id || bus.out_tag !== e.tag ||
            cyc - iss[0] != S) begin
          errs++;
          $display("FAIL contend_out: id=%b tag=%0d lat=%0d req %b/%0d/%0d",
                   bus.out_id, bus.out_tag, cyc - iss[0],
                   e.id, e.tag, S);
        end
        void'(iss.pop_front());
      end
      tick();
    end
    vec++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL contend_missing: left=%0d req 0", q.size());
    end
    drain();
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    set1(0, 0, 0, 0, 0);
    for (int k = 0; k < S; k++) begin
      set0(1, 0, 0, 0, TW'(8 + k));
      #1;
      vec++;
      if (bus.in0_ready !== 1'b1) begin
        errs++;
        $display("FAIL stall_fill%0d: r0=%b req 1", k, bus.in0_ready);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      set0(1, 0, 0, 0, 4'd12);
      set1(1, 0, 0, 0, 4'd13);
      #1;
      vec++;
      if (st_en !== '0 || bus.in0_ready !== 1'b0 ||
          bus.in1_ready !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold%0d: en=%b r0=%b r1=%b req 0/0/0",
                 k, st_en, bus.in0_ready, bus.in1_ready);
      end
      vec++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== 4'd8 ||
          inflight !== CW'(S)) begin
        errs++;
        $display("FAIL stall_out%0d: ov=%b tag=%0d inf=%0d req 1/8/%0d",
                 k, bus.out_valid, bus.out_tag, inflight, S);
      end
      tick();
    end
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < S; k++) begin
      #1;
      vec++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== TW'(8 + k)) begin
        errs++;
        $display("FAIL stall_rel%0d: ov=%b tag=%0d req 1/%0d",
                 k, bus.out_valid, bus.out_tag, 8 + k);
      end
      tick();
    end
    vec++;
    if (bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL stall_end: ov=%b req 0", bus.out_valid);
    end
  endtask

  task automatic test_signs();
    logic [2:0] combo [3];
    logic       exp_sx [3];
    combo[0] = 3'b100; exp_sx[0] = 1'b1;
    combo[1] = 3'b111; exp_sx[1] = 1'b1;
    combo[2] = 3'b011; exp_sx[2] = 1'b0;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      set1(1, combo[j][0], combo[j][2], combo[j][1], TW'(j));
      tick();
      set1(0, 0, 0, 0, 0);
      repeat (SG - 1) tick();
      vec++;
      if (sx_sig !== exp_sx[j]) begin
        errs++;
        $display("FAIL sign_%0d: sx_sig=%b req %b", j, sx_sig, exp_sx[j]);
      end
      repeat (S) tick();
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b1;
    set1(0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      set0(1, 0, 0, 0, TW'(k + 1));
      tick();
    end
    set0(0, 0, 0, 0, 0);
    vec++;
    if (inflight !== CW'(3)) begin
      errs++;
      $display("FAIL flush_pre: inflight=%0d req 3", inflight);
    end
    flush = 1'b1;
    set1(1, 1, 1, 1, 4'd9);
    #1;
    vec++;
    if (bus.in1_ready !== 1'b0 || bus.in0_ready !== 1'b0) begin
      errs++;
      $display("FAIL flush_ready: r0=%b r1=%b req 0/0",
               bus.in0_ready, bus.in1_ready);
    end
    tick();
    flush = 1'b0;
    set1(0, 0, 0, 0, 0);
    vec++;
    if (inflight !== '0) begin
      errs++;
      $display("FAIL flush_clear: inflight=%0d req 0", inflight);
    end
    for (int t = 0; t < S + 2; t++) begin
      vec++;
      if (bus.out_valid !== 1'b0) begin
        errs++;
        $display("FAIL flush_ghost%0d: ov=%b req 0", t, bus.out_valid);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    bus.out_ready = 1'b0;
    set1(0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      set0(1, 0, 1, 0, TW'(k + 4));
      tick();
    end
    set0(0, 0, 0, 0, 0);
    for (int t = 0; t < 10 && !seen; t++) begin
      if (bus.out_valid) seen = 1;
      else tick();
    end
    tick();
    vec++;
    if (!seen || bus.out_valid !== 1'b1 || inflight !== CW'(2)) begin
      errs++;
      $display("FAIL arst_pre: seen=%0d ov=%b inf=%0d req 1/1/2",
               seen, bus.out_valid, inflight);
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (bus.out_valid !== 1'b0 || inflight !== '0 ||
        sx_sig !== 1'b0) begin
      errs++;
      $display("FAIL arst_drop: ov=%b inf=%0d sx=%b req 0/0/0",
               bus.out_valid, inflight, sx_sig);
    end
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set0(1, 0, 0, 0, 4'd1);
    set1(1, 0, 0, 0, 4'd2);
    #1;
    vec++;
    if (bus.in0_ready !== 1'b1 || bus.in1_ready !== 1'b0 ||
        op_sel !== 1'b0) begin
      errs++;
      $display("FAIL arst_tie: r0=%b r1=%b sel=%b req 1/0/0",
               bus.in0_ready, bus.in1_ready, op_sel);
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    slot_t last;
    for (int n = 0; n < 400; n++) begin
      set0(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
           1'($urandom), TW'($urandom));
      set1(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom),
           1'($urandom), TW'($urandom));
      bus.out_ready = 1'($urandom_range(0, 9) < 7);
      flush = 1'($urandom_range(0, 19) == 0);
      #1;
      m_expect();
      last = pipe[S-1];
      vec++;
      if (bus.in0_ready !== e_r0 || bus.in1_ready !== e_r1 ||
          st_en !== {S{e_adv}} ||
          (e_any && op_sel !== e_sel)) begin
        errs++;
        $display("FAIL rnd_issue%0d: r0=%b r1=%b en=%b sel=%b req %b/%b/%b/%b",
                 n, bus.in0_ready, bus.in1_ready, st_en, op_sel,
                 e_r0, e_r1, e_adv, e_sel);
      end
      vec++;
      if (bus.out_valid !== last.v ||
          (last.v && (bus.out_id !== last.id ||
                      bus.out_tag !== last.tag)) ||
          sx_sig !== (pipe[SG-1].v & pipe[SG-1].sx) ||
          inflight !== CW'(m_count())) begin
        errs++;
        $display("FAIL rnd_state%0d: ov=%b id=%b tag=%0d sx=%b inf=%0d req %b/%b/%0d/%b/%0d",
                 n, bus.out_valid, bus.out_id, bus.out_tag, sx_sig,
                 inflight, last.v, last.id, last.tag,
                 pipe[SG-1].v & pipe[SG-1].sx, m_count());
      end
      tick();
    end
    drain();
  endtask

  initial begin
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    m_reset();
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_signs();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
